// File: rtl/fetch_unit.sv
// Instruction fetch unit: credit-limited request issue, in-order prefetch queue,
// redirect flush with stale-response drop. Optional FETCH_MISALIGN_CHECK_EN.
module fetch_unit #(
    parameter int          QDEPTH   = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    output logic        imemReqValid,
    input  logic        imemReqReady,
    output logic [31:0] imemReqAddr,
    input  logic        imemRespValid,
    input  logic [31:0] imemRespData,
    input  logic        redirect,
    input  logic [31:0] redirectPc,
    output logic        instValid,
    input  logic        instReady,
    output logic [31:0] instruction,
    output logic [31:0] pc,
    output logic        misalign
);

    localparam int CW = $clog2(QDEPTH + 1);
    localparam int PW = $clog2(QDEPTH);

    logic [31:0]   fpc;
    logic [CW-1:0] inflight;
    logic [CW-1:0] inflight_nxt;
    logic [CW-1:0] count;
    logic [CW-1:0] count_nxt;
    logic [CW-1:0] drop;
    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic [31:0]   qpc [QDEPTH];
    logic [31:0]   qins [QDEPTH];

    logic hold;
    logic credit;
    logic accept;
    logic push;
    logic pop;

    function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
        return (p == PW'(QDEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

`ifdef FETCH_MISALIGN_CHECK_EN
    logic mis_q;

    always_ff @(posedge clk) begin
        if (rst)
            mis_q <= 1'b0;
        else if (redirect)
            mis_q <= |redirectPc[1:0];
    end

    assign hold = mis_q;
`else
    assign hold = 1'b0;
`endif

    assign misalign = hold;

    // Queued entries and outstanding requests share one credit pool
    assign credit = ((CW+1)'(inflight) + (CW+1)'(count)) < (CW+1)'(QDEPTH);

    assign imemReqValid = !rst && !redirect && !hold && credit;
    assign imemReqAddr  = fpc;
    assign accept       = imemReqValid && imemReqReady;

    assign push = imemRespValid && !redirect && (drop == '0);
    assign pop  = instValid && instReady && !stall && !redirect;

    assign instValid   = (count != '0);
    assign instruction = qins[head];
    assign pc          = qpc[head];

    always_comb begin
        inflight_nxt = inflight;
        unique case ({accept, imemRespValid})
            2'b10:   inflight_nxt = inflight + 1'b1;
            2'b01:   inflight_nxt = inflight - 1'b1;
            default: inflight_nxt = inflight;
        endcase
    end

    always_comb begin
        count_nxt = count;
        unique case ({push, pop})
            2'b10:   count_nxt = count + 1'b1;
            2'b01:   count_nxt = count - 1'b1;
            default: count_nxt = count;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fpc      <= RESET_PC;
            inflight <= '0;
            count    <= '0;
            drop     <= '0;
            head     <= '0;
            tail     <= '0;
        end else begin
            inflight <= inflight_nxt;
            if (redirect) begin
                // Everything still outstanding after this cycle is stale
                fpc   <= {redirectPc[31:2], redirectPc[1:0] & 2'b00};
                count <= '0;
                head  <= '0;
                tail  <= '0;
                drop  <= inflight_nxt;
            end else begin
                if (accept)
                    fpc <= fpc + 32'd4;
                if (imemRespValid && (drop != '0))
                    drop <= drop - 1'b1;
                if (push)
                    tail <= inc(tail);
                if (pop)
                    head <= inc(head);
                count <= count_nxt;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            qpc[tail]  <= fpc_of_resp();
            qins[tail] <= imemRespData;
        end
    end

    // PC of the returning response: issue address minus words still in flight
    function automatic logic [31:0] fpc_of_resp();
        return fpc - {{(30-CW){1'b0}}, inflight, 2'b00};
    endfunction

endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit with a latency-programmable
// in-order instruction memory model and a delivered-instruction log.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        imemReqValid;
    logic        imemReqReady;
    logic [31:0] imemReqAddr;
    logic        imemRespValid = 1'b0;
    logic [31:0] imemRespData = 32'h0;
    logic        redirect;
    logic [31:0] redirectPc;
    logic        instValid;
    logic        instReady;
    logic [31:0] instruction;
    logic [31:0] pc;
    logic        misalign;

    fetch_unit #(.QDEPTH(4), .RESET_PC(32'h0000_0000)) dut (
        .clk          (clk),
        .rst          (rst),
        .stall        (stall),
        .imemReqValid (imemReqValid),
        .imemReqReady (imemReqReady),
        .imemReqAddr  (imemReqAddr),
        .imemRespValid(imemRespValid),
        .imemRespData (imemRespData),
        .redirect     (redirect),
        .redirectPc   (redirectPc),
        .instValid    (instValid),
        .instReady    (instReady),
        .instruction  (instruction),
        .pc           (pc),
        .misalign     (misalign)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] f(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'hDEAD_BEEF;
    endfunction

    typedef struct {
        int          due;
        logic [31:0] a;
    } ent_t;

    ent_t        pend[$];
    int          cyc  = 0;
    int          lat  = 1;
    int          nacc = 0;
    logic [31:0] lpc[$];
    logic [31:0] lins[$];

    always @(posedge clk) begin
        if (rst) begin
            pend.delete();
            imemRespValid <= 1'b0;
        end else begin
            if (imemReqValid && imemReqReady) begin
                pend.push_back('{due: cyc + lat, a: imemReqAddr});
                nacc++;
            end
            if (pend.size() > 0 && pend[0].due <= cyc + 1) begin
                imemRespValid <= 1'b1;
                imemRespData  <= f(pend[0].a);
                void'(pend.pop_front());
            end else begin
                imemRespValid <= 1'b0;
            end
        end
        cyc++;
    end

    always @(posedge clk) begin
        if (!rst && instValid && instReady && !stall && !redirect) begin
            lpc.push_back(pc);
            lins.push_back(instruction);
        end
    end

    int          nchk = 0;
    int          nfail = 0;
    int          rd = 0;
    logic [31:0] epc = 32'h0;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_log(input string tag);
        while (rd < lpc.size()) begin
            chk({tag, "_pc"}, lpc[rd], epc);
            chk({tag, "_ins"}, lins[rd], f(epc));
            epc = epc + 32'd4;
            rd++;
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_redirect(input logic [31:0] target);
        check_log("pre_redir");
        redirect   = 1'b1;
        redirectPc = target;
        cycles(1);
        redirect = 1'b0;
        #1;
    endtask

    initial begin
        rst          = 1'b1;
        stall        = 1'b0;
        instReady    = 1'b1;
        redirect     = 1'b0;
        redirectPc   = 32'h0;
        imemReqReady = 1'b1;

        repeat (2) @(posedge clk);
        @(negedge clk); #1;
        chk("rst_reqv", 32'(imemReqValid), 32'd0);
        chk("rst_instv", 32'(instValid), 32'd0);
        chk("rst_mis", 32'(misalign), 32'd0);
        rst = 1'b0; #1;
        chk("first_reqv", 32'(imemReqValid), 32'd1);
        chk("first_addr", imemReqAddr, 32'h0);
        cycles(1); #1;
        chk("lat_instv", 32'(instValid), 32'd0);
        cycles(1); #1;
        chk("first_instv", 32'(instValid), 32'd1);
        chk("first_pc", pc, 32'h0);
        chk("first_ins", instruction, f(32'h0));
        cycles(1); #1;
        chk("second_pc", pc, 32'h4);
        cycles(4);
        check_log("seq");

        instReady = 1'b0;
        cycles(10); #1;
        check_log("bp");
        chk("bp_reqv", 32'(imemReqValid), 32'd0);
        chk("bp_outstanding", 32'(nacc - lpc.size()), 32'd4);
        chk("bp_hold_pc", pc, epc);
        cycles(1); #1;
        chk("bp_hold_pc2", pc, epc);
        chk("bp_hold_ins", instruction, f(epc));
        instReady = 1'b1;
        cycles(10);
        check_log("bp_resume");

        lat          = 3;
        imemReqReady = 1'b0;
        cycles(10); #1;
        check_log("drain");
        chk("drain_instv", 32'(instValid), 32'd0);
        imemReqReady = 1'b1;
        cycles(2);
        redirect   = 1'b1;
        redirectPc = 32'h100;
        #1;
        chk("rd_reqv_low", 32'(imemReqValid), 32'd0);
        cycles(1);
        redirect = 1'b0;
        #1;
        chk("rd_instv", 32'(instValid), 32'd0);
        chk("rd_reqv", 32'(imemReqValid), 32'd1);
        chk("rd_addr", imemReqAddr, 32'h100);
        epc = 32'h100;
        cycles(12); #1;
        chk("rd_cnt", 32'(lpc.size() - rd >= 2), 32'd1);
        check_log("redir");

        check_log("pre_b2b");
        redirect   = 1'b1;
        redirectPc = 32'h300;
        cycles(1);
        redirectPc = 32'h500;
        cycles(1);
        redirect = 1'b0;
        epc = 32'h500;
        cycles(15); #1;
        chk("b2b_cnt", 32'(lpc.size() - rd >= 3), 32'd1);
        check_log("b2b");

        lat = 1;
        cycles(6);
        check_log("lat1");
        stall = 1'b1;
        cycles(8); #1;
        check_log("stall");
        chk("st_instv", 32'(instValid), 32'd1);
        chk("st_pc", pc, epc);
        chk("st_full_reqv", 32'(imemReqValid), 32'd0);
        redirect   = 1'b1;
        redirectPc = 32'h40;
        cycles(1);
        redirect = 1'b0;
        stall    = 1'b0;
        #1;
        chk("st_flush", 32'(instValid), 32'd0);
        epc = 32'h40;
        cycles(8); #1;
        chk("st_cnt", 32'(lpc.size() - rd >= 3), 32'd1);
        check_log("stall_redir");

        pulse_redirect(32'hFFFF_FFF8);
        epc = 32'hFFFF_FFF8;
        cycles(8); #1;
        chk("wrap_cnt", 32'(lpc.size() - rd >= 4), 32'd1);
        check_log("wrap");

        pulse_redirect(32'h102);
`ifdef FETCH_MISALIGN_CHECK_EN
        chk("mis_set", 32'(misalign), 32'd1);
        cycles(6); #1;
        chk("mis_sticky", 32'(misalign), 32'd1);
        chk("mis_reqv", 32'(imemReqValid), 32'd0);
        chk("mis_instv", 32'(instValid), 32'd0);
        chk("mis_nolog", 32'(lpc.size()), 32'(rd));
        pulse_redirect(32'h200);
        chk("mis_clr", 32'(misalign), 32'd0);
        chk("mis_addr", imemReqAddr, 32'h200);
        epc = 32'h200;
`else
        chk("mis_tied", 32'(misalign), 32'd0);
        chk("mis_addr", imemReqAddr, 32'h100);
        epc = 32'h100;
`endif
        cycles(8); #1;
        chk("mis_cnt", 32'(lpc.size() - rd >= 3), 32'd1);
        check_log("mis_resume");

        check_log("pre_rst");
        rst = 1'b1;
        cycles(2); #1;
        chk("midrst_reqv", 32'(imemReqValid), 32'd0);
        chk("midrst_instv", 32'(instValid), 32'd0);
        rst = 1'b0; #1;
        chk("postrst_addr", imemReqAddr, 32'h0);
        epc = 32'h0;
        cycles(8); #1;
        chk("postrst_cnt", 32'(lpc.size() - rd >= 3), 32'd1);
        check_log("post_rst");

        $display("End of test - %0d assertions evaluated, %0d failures",
                 nchk, nfail);
        $finish;
    end

endmodule
